// File: rtl/ca_eval_sequencer.sv
// Evaluation sequencer for a cellular-automaton cell array: loads the LUT configuration
// over S2, writes input/control words over S1, launches S3, waits, then reads back the result.
module ca_eval_sequencer #(
  parameter int CFG_WORDS = 512,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int STEP_W    = 16,
  parameter int SETTLE    = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              skip_cfg,
  input  logic [DATA_W-1:0] in_word,
  input  logic [DATA_W-1:0] ctrl_word,
  input  logic [STEP_W-1:0] steps,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              s1_read,
  output logic              s1_write,
  output logic              s1_address,
  output logic [DATA_W-1:0] s1_writedata,
  input  logic [DATA_W-1:0] s1_readdata,
  output logic              s2_write,
  output logic [ADDR_W-1:0] s2_address,
  output logic [DATA_W-1:0] s2_writedata,
  output logic              s3_write,
  output logic [STEP_W-1:0] s3_writedata
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_WR_IN,
    ST_WR_CTRL,
    ST_RUN,
    ST_WAIT,
    ST_READ,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CFG_WORDS - 1);
  localparam logic [STEP_W:0]   SETTLE_CYC = (STEP_W + 1)'(SETTLE);

  if ((2 ** ADDR_W) < CFG_WORDS) begin : g_addr_check
    $error("ca_eval_sequencer: ADDR_W too narrow to address CFG_WORDS");
  end

  state_t              state;
  state_t              state_nxt;
  logic [STEP_W-1:0]   steps_q;
  logic [DATA_W-1:0]   in_q;
  logic [DATA_W-1:0]   ctrl_q;
  logic [ADDR_W-1:0]   cfg_cnt;
  logic [STEP_W:0]     wait_left;
  logic [STEP_W:0]     wait_total;
  logic                capture_q;

  // Next values of the registered outputs, decoded from the current state.
  logic                s1_read_d;
  logic                s1_write_d;
  logic                s1_address_d;
  logic [DATA_W-1:0]   s1_writedata_d;
  logic                s2_write_d;
  logic [ADDR_W-1:0]   s2_address_d;
  logic [DATA_W-1:0]   s2_writedata_d;
  logic                s3_write_d;
  logic [STEP_W-1:0]   s3_writedata_d;
  logic                capture_d;
  logic                done_d;

  // One extra bit keeps steps = all-ones plus SETTLE from wrapping.
  assign wait_total = {1'b0, steps_q} + SETTLE_CYC;

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = skip_cfg ? ST_WR_IN : ST_CFG;
        end
      end
      ST_CFG: begin
        if (cfg_valid && (cfg_cnt == '0)) begin
          state_nxt = ST_WR_IN;
        end
      end
      ST_WR_IN:   state_nxt = ST_WR_CTRL;
      ST_WR_CTRL: state_nxt = ST_RUN;
      ST_RUN:     state_nxt = (wait_total == '0) ? ST_READ : ST_WAIT;
      ST_WAIT: begin
        if (wait_left == (STEP_W + 1)'(1)) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ:    state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; address/data hold their value unless a strobe reloads them.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    cfg_ready      = (state == ST_CFG);
    s1_read_d      = 1'b0;
    s1_write_d     = 1'b0;
    s1_address_d   = s1_address;
    s1_writedata_d = s1_writedata;
    s2_write_d     = 1'b0;
    s2_address_d   = s2_address;
    s2_writedata_d = s2_writedata;
    s3_write_d     = 1'b0;
    s3_writedata_d = s3_writedata;
    capture_d      = 1'b0;
    done_d         = 1'b0;
    unique case (state)
      ST_CFG: begin
        if (cfg_valid) begin
          s2_write_d     = 1'b1;
          s2_address_d   = cfg_cnt;
          s2_writedata_d = cfg_data;
        end
      end
      ST_WR_IN: begin
        s1_write_d     = 1'b1;
        s1_address_d   = 1'b1;
        s1_writedata_d = in_q;
      end
      ST_WR_CTRL: begin
        s1_write_d     = 1'b1;
        s1_address_d   = 1'b0;
        s1_writedata_d = ctrl_q;
      end
      ST_RUN: begin
        s3_write_d     = 1'b1;
        s3_writedata_d = steps_q;
      end
      ST_READ: begin
        s1_read_d    = 1'b1;
        s1_address_d = 1'b0;
      end
      ST_CAPTURE: capture_d = 1'b1;
      ST_DONE:    done_d    = 1'b1;
      default: ;
    endcase
  end

  // Request latches, configuration address counter and wait counter.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      steps_q   <= '0;
      in_q      <= '0;
      ctrl_q    <= '0;
      cfg_cnt   <= LAST_ADDR;
      wait_left <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        steps_q <= steps;
        in_q    <= in_word;
        ctrl_q  <= ctrl_word;
        cfg_cnt <= LAST_ADDR;
      end
      if ((state == ST_CFG) && cfg_valid) begin
        cfg_cnt <= cfg_cnt - 1'b1;
      end
      if (state == ST_RUN) begin
        wait_left <= wait_total;
      end else if (state == ST_WAIT) begin
        wait_left <= wait_left - 1'b1;
      end
    end
  end

  // Registered outputs: each strobe appears the cycle after the state that issues it.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      s1_read      <= 1'b0;
      s1_write     <= 1'b0;
      s1_address   <= 1'b0;
      s1_writedata <= '0;
      s2_write     <= 1'b0;
      s2_address   <= LAST_ADDR;
      s2_writedata <= '0;
      s3_write     <= 1'b0;
      s3_writedata <= '0;
      capture_q    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
    end else begin
      s1_read      <= s1_read_d;
      s1_write     <= s1_write_d;
      s1_address   <= s1_address_d;
      s1_writedata <= s1_writedata_d;
      s2_write     <= s2_write_d;
      s2_address   <= s2_address_d;
      s2_writedata <= s2_writedata_d;
      s3_write     <= s3_write_d;
      s3_writedata <= s3_writedata_d;
      capture_q    <= capture_d;
      busy         <= (state_nxt != ST_IDLE);
      done         <= done_d;
      // Read data arrives one cycle after s1_read is seen, i.e. the cycle after CAPTURE.
      if (capture_q) begin
        result <= s1_readdata;
      end
    end
  end

endmodule

// File: tb/tb_ca_eval_sequencer.sv
// Randomized self-checking bench for ca_eval_sequencer: cfg stream source, S1 slave model,
// bus monitor and per-scenario checks against latencies and orderings derived from the rules.
module tb_ca_eval_sequencer;

  localparam int CFG_WORDS = 512;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int STEP_W    = 16;
  localparam int SETTLE    = 4;

  logic              clk_in = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              skip_cfg = 1'b0;
  logic [DATA_W-1:0] in_word = '0;
  logic [DATA_W-1:0] ctrl_word = '0;
  logic [STEP_W-1:0] steps = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              s1_read;
  logic              s1_write;
  logic              s1_address;
  logic [DATA_W-1:0] s1_writedata;
  logic [DATA_W-1:0] s1_readdata = '0;
  logic              s2_write;
  logic [ADDR_W-1:0] s2_address;
  logic [DATA_W-1:0] s2_writedata;
  logic              s3_write;
  logic [STEP_W-1:0] s3_writedata;

  ca_eval_sequencer #(
    .CFG_WORDS(CFG_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STEP_W(STEP_W), .SETTLE(SETTLE)
  ) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .skip_cfg(skip_cfg),
    .in_word(in_word), .ctrl_word(ctrl_word), .steps(steps),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .busy(busy), .done(done), .result(result),
    .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s2_write(s2_write), .s2_address(s2_address), .s2_writedata(s2_writedata),
    .s3_write(s3_write), .s3_writedata(s3_writedata)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Logs filled by the monitor, cleared at the start of each scenario.
  logic [ADDR_W-1:0] s2_addr_q[$];
  logic [DATA_W-1:0] s2_data_q[$];
  logic              s1_addr_q[$];
  logic [DATA_W-1:0] s1_data_q[$];
  logic [STEP_W-1:0] s3_q[$];
  int                s3_cyc, done_cyc, done_cnt, start_cyc;
  int                viol = 0;
  logic              ready_at_last_s2, busy_at_done, s3_prev = 1'b0;

  // Configuration source state and expected word sequence.
  logic [DATA_W-1:0] cfg_words[$];
  logic [DATA_W-1:0] cfg_sent[$];
  int                cfg_mode = 0;
  logic [DATA_W-1:0] rd_value = '0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // S1 slave: one-cycle read latency, garbage on every other cycle.
  always @(posedge clk_in) s1_readdata <= s1_read ? rd_value : DATA_W'($urandom());

  // Configuration stream source: mode 0 always valid, 1 every other cycle, 2 random.
  always @(negedge clk_in) begin
    logic pat;
    case (cfg_mode)
      0:       pat = 1'b1;
      1:       pat = cyc[0];
      default: pat = 1'($urandom_range(0, 1));
    endcase
    cfg_valid = (cfg_words.size() > 0) && pat;
    cfg_data  = cfg_valid ? cfg_words[0] : DATA_W'($urandom());
    if (cfg_valid && cfg_ready && rst) void'(cfg_words.pop_front());
  end

  // Bus monitor and exclusivity rules on every cycle.
  always @(negedge clk_in) begin
    if (s2_write) begin
      s2_addr_q.push_back(s2_address);
      s2_data_q.push_back(s2_writedata);
      ready_at_last_s2 = cfg_ready;
    end
    if (s1_write) begin
      s1_addr_q.push_back(s1_address);
      s1_data_q.push_back(s1_writedata);
    end
    if (s3_write) begin
      s3_q.push_back(s3_writedata);
      s3_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (s1_read && s1_write) viol++;
    if ((int'(s1_write) + int'(s2_write) + int'(s3_write)) > 1) viol++;
    if (s3_write && s3_prev) viol++;
    if (cfg_ready && !busy) viol++;
    s3_prev = s3_write;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: S2 writes must hit addresses CFG_WORDS-1 down to 0 with the words in send order.
  function automatic int cfg_errors();
    int e = 0;
    int n = (s2_addr_q.size() < cfg_sent.size()) ? s2_addr_q.size() : cfg_sent.size();
    e = (s2_addr_q.size() > cfg_sent.size()) ? s2_addr_q.size() - cfg_sent.size()
                                             : cfg_sent.size() - s2_addr_q.size();
    for (int i = 0; i < n; i++) begin
      if (s2_addr_q[i] !== ADDR_W'(CFG_WORDS - 1 - i)) e++;
      if (s2_data_q[i] !== cfg_sent[i]) e++;
    end
    return e;
  endfunction

  // Reference model: exactly in_word at address 1, then ctrl_word at address 0.
  function automatic int s1_errors(input logic [DATA_W-1:0] iw, input logic [DATA_W-1:0] cw);
    if (s1_addr_q.size() != 2) return 100 + s1_addr_q.size();
    return int'(s1_addr_q[0] !== 1'b1) + int'(s1_data_q[0] !== iw) +
           int'(s1_addr_q[1] !== 1'b0) + int'(s1_data_q[1] !== cw);
  endfunction

  function automatic logic [STEP_W-1:0] s3_only();
    return (s3_q.size() == 1) ? s3_q[0] : 'x;
  endfunction

  task automatic clear_logs();
    s2_addr_q.delete(); s2_data_q.delete(); s1_addr_q.delete(); s1_data_q.delete();
    s3_q.delete(); cfg_sent.delete(); cfg_words.delete();
    done_cnt = 0; done_cyc = -1; s3_cyc = -1; ready_at_last_s2 = 1'bx; busy_at_done = 1'bx;
  endtask

  task automatic load_cfg(input bit fixed, input logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < CFG_WORDS; i++) begin
      w = fixed ? value : DATA_W'($urandom());
      cfg_words.push_back(w);
      cfg_sent.push_back(w);
    end
  endtask

  task automatic launch(input logic skip, input logic [STEP_W-1:0] st,
                        input logic [DATA_W-1:0] iw, input logic [DATA_W-1:0] cw);
    @(negedge clk_in);
    skip_cfg = skip; steps = st; in_word = iw; ctrl_word = cw; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk_in);
    start = 1'b0; skip_cfg = 1'($urandom()); steps = STEP_W'($urandom());
    in_word = DATA_W'($urandom()); ctrl_word = DATA_W'($urandom());
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int n = 0;
    timed_out = 1'b1;
    while (n < budget) begin
      @(negedge clk_in);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      n++;
    end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({busy, done, cfg_ready, s1_read, s1_write, s2_write, s3_write} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0000000",
               {busy, done, cfg_ready, s1_read, s1_write, s2_write, s3_write});
    end
    n_checks++;
    if (s2_address !== ADDR_W'(CFG_WORDS - 1)) begin
      n_fail++; $display("FAIL reset_s2_address: got %0d required %0d", s2_address, CFG_WORDS - 1);
    end
    n_checks++;
    if ({s1_address, s1_writedata, s2_writedata, s3_writedata, result} !== '0) begin
      n_fail++; $display("FAIL reset_data: s1a=%0d s1d=%h s2d=%h s3d=%h res=%h required all 0",
                         s1_address, s1_writedata, s2_writedata, s3_writedata, result);
    end
    @(negedge clk_in);
    rst = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_full_eval();
    bit to;
    clear_logs(); load_cfg(1'b1, 32'h5555_5555); cfg_mode = 0; rd_value = DATA_W'($urandom());
    launch(1'b0, 16'd100, 32'hDEAD_BEEF, 32'hABCD_EF12);
    wait_done(2000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL full_timeout: done not seen within 2000 cycles"); end
    n_checks++; if (s2_addr_q.size() != CFG_WORDS) begin n_fail++; $display("FAIL full_s2_count: got %0d required %0d", s2_addr_q.size(), CFG_WORDS); end
    n_checks++; if (cfg_errors() != 0) begin n_fail++; $display("FAIL full_s2_seq: %0d address/data errors, required 0", cfg_errors()); end
    n_checks++; if (s1_errors(32'hDEAD_BEEF, 32'hABCD_EF12) != 0) begin n_fail++; $display("FAIL full_s1_writes: %0d errors, required 0", s1_errors(32'hDEAD_BEEF, 32'hABCD_EF12)); end
    n_checks++; if (s3_only() !== 16'd100) begin n_fail++; $display("FAIL full_s3: got %h (count %0d) required 100", s3_only(), s3_q.size()); end
    n_checks++; if (done_cyc - s3_cyc != 100 + SETTLE + 3) begin n_fail++; $display("FAIL full_done_after_s3: got %0d required %0d", done_cyc - s3_cyc, 100 + SETTLE + 3); end
    n_checks++; if (result !== rd_value) begin n_fail++; $display("FAIL full_result: got %h required %h", result, rd_value); end
    n_checks++; if ({done_cnt == 1, busy_at_done} !== 2'b10) begin n_fail++; $display("FAIL full_done_busy: done count %0d busy at done %b, required 1 and 0", done_cnt, busy_at_done); end
  endtask

  task automatic test_skip_min();
    bit to;
    clear_logs(); rd_value = DATA_W'($urandom());
    launch(1'b1, 16'd0, 32'h1111_2222, 32'h3333_4444);
    wait_done(100, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL skip_timeout: done not seen within 100 cycles"); end
    n_checks++; if (s2_addr_q.size() != 0) begin n_fail++; $display("FAIL skip_s2_count: got %0d required 0", s2_addr_q.size()); end
    n_checks++; if (done_cyc - start_cyc != 7 + SETTLE) begin n_fail++; $display("FAIL skip_latency: got %0d required %0d", done_cyc - start_cyc, 7 + SETTLE); end
    n_checks++; if (s1_errors(32'h1111_2222, 32'h3333_4444) != 0) begin n_fail++; $display("FAIL skip_s1_writes: %0d errors, required 0", s1_errors(32'h1111_2222, 32'h3333_4444)); end
    n_checks++; if (result !== rd_value) begin n_fail++; $display("FAIL skip_result: got %h required %h", result, rd_value); end
  endtask

  task automatic test_cfg_toggle();
    bit to;
    logic [STEP_W-1:0] st = STEP_W'($urandom_range(1, 30));
    clear_logs(); load_cfg(1'b0, '0); cfg_mode = 1; rd_value = DATA_W'($urandom());
    launch(1'b0, st, 32'h0BAD_F00D, 32'h600D_CAFE);
    wait_done(3000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL toggle_timeout: done not seen within 3000 cycles"); end
    n_checks++; if (cfg_errors() != 0) begin n_fail++; $display("FAIL toggle_s2_seq: %0d errors over %0d writes, required 0", cfg_errors(), s2_addr_q.size()); end
    n_checks++; if (ready_at_last_s2 !== 1'b0) begin n_fail++; $display("FAIL toggle_ready_after_last: got %b required 0", ready_at_last_s2); end
    n_checks++; if (done_cyc - s3_cyc != int'(st) + SETTLE + 3) begin n_fail++; $display("FAIL toggle_done_after_s3: got %0d required %0d", done_cyc - s3_cyc, int'(st) + SETTLE + 3); end
    n_checks++; if (result !== rd_value) begin n_fail++; $display("FAIL toggle_result: got %h required %h", result, rd_value); end
    cfg_mode = 0;
  endtask

  task automatic test_start_during_wait();
    bit to;
    clear_logs(); rd_value = DATA_W'($urandom());
    launch(1'b1, 16'd50, 32'hAAAA_0001, 32'hBBBB_0002);
    repeat (20) @(negedge clk_in);
    skip_cfg = 1'b0; steps = 16'd7; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    wait_done(200, to);
    repeat (80) @(negedge clk_in);
    n_checks++; if (to) begin n_fail++; $display("FAIL wait_start_timeout: done not seen within 200 cycles"); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL wait_start_done_count: got %0d required 1", done_cnt); end
    n_checks++; if (s3_only() !== 16'd50) begin n_fail++; $display("FAIL wait_start_steps: got %h (count %0d) required 50", s3_only(), s3_q.size()); end
    n_checks++; if (done_cyc - start_cyc != 7 + 50 + SETTLE) begin n_fail++; $display("FAIL wait_start_latency: got %0d required %0d", done_cyc - start_cyc, 7 + 50 + SETTLE); end
    n_checks++; if (s2_addr_q.size() != 0) begin n_fail++; $display("FAIL wait_start_s2: got %0d writes required 0", s2_addr_q.size()); end
  endtask

  task automatic test_reset_mid_cfg();
    bit to;
    int n = 0;
    clear_logs(); load_cfg(1'b0, '0); cfg_mode = 0;
    launch(1'b0, 16'd5, 32'h1234_5678, 32'h8765_4321);
    while (s2_addr_q.size() < 200 && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    rst = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if ({busy, done, cfg_ready, s1_read, s1_write, s2_write, s3_write} !== 7'b0) begin
      n_fail++; $display("FAIL midcfg_reset_strobes: got %b required 0000000",
                         {busy, done, cfg_ready, s1_read, s1_write, s2_write, s3_write});
    end
    n_checks++;
    if (s2_address !== ADDR_W'(CFG_WORDS - 1) || {s2_writedata, s1_writedata, result} !== '0) begin
      n_fail++; $display("FAIL midcfg_reset_values: s2a=%0d s2d=%h s1d=%h res=%h required %0d,0,0,0",
                         s2_address, s2_writedata, s1_writedata, result, CFG_WORDS - 1);
    end
    rst = 1'b1;
    clear_logs(); load_cfg(1'b0, '0); rd_value = DATA_W'($urandom());
    launch(1'b0, 16'd3, 32'hC0DE_0001, 32'hC0DE_0000);
    wait_done(2000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL midcfg_restart_timeout: done not seen within 2000 cycles"); end
    n_checks++; if (s2_addr_q.size() == 0 || s2_addr_q[0] !== ADDR_W'(CFG_WORDS - 1)) begin n_fail++; $display("FAIL midcfg_restart_first_addr: %0d writes, required first address %0d", s2_addr_q.size(), CFG_WORDS - 1); end
    n_checks++; if (cfg_errors() != 0) begin n_fail++; $display("FAIL midcfg_restart_seq: %0d errors, required 0", cfg_errors()); end
    n_checks++; if (result !== rd_value) begin n_fail++; $display("FAIL midcfg_restart_result: got %h required %h", result, rd_value); end
  endtask

  task automatic test_random();
    bit to;
    logic skip;
    logic [STEP_W-1:0] st;
    logic [DATA_W-1:0] iw, cw;
    for (int it = 0; it < 3; it++) begin
      skip = (it == 1); st = STEP_W'($urandom_range(0, 40));
      iw = DATA_W'($urandom()); cw = DATA_W'($urandom());
      clear_logs(); if (!skip) load_cfg(1'b0, '0);
      cfg_mode = 2; rd_value = DATA_W'($urandom());
      launch(skip, st, iw, cw);
      wait_done(4000, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: done not seen", it); end
      n_checks++; if (cfg_errors() != 0) begin n_fail++; $display("FAIL rand%0d_s2_seq: %0d errors, required 0", it, cfg_errors()); end
      n_checks++; if (s1_errors(iw, cw) != 0) begin n_fail++; $display("FAIL rand%0d_s1_writes: %0d errors, required 0", it, s1_errors(iw, cw)); end
      n_checks++; if (s3_only() !== st) begin n_fail++; $display("FAIL rand%0d_s3: got %h required %h", it, s3_only(), st); end
      n_checks++; if (done_cyc - s3_cyc != int'(st) + SETTLE + 3) begin n_fail++; $display("FAIL rand%0d_done_after_s3: got %0d required %0d", it, done_cyc - s3_cyc, int'(st) + SETTLE + 3); end
      n_checks++; if (result !== rd_value) begin n_fail++; $display("FAIL rand%0d_result: got %h required %h", it, result, rd_value); end
      if (skip) begin
        n_checks++; if (done_cyc - start_cyc != 7 + int'(st) + SETTLE) begin n_fail++; $display("FAIL rand%0d_latency: got %0d required %0d", it, done_cyc - start_cyc, 7 + int'(st) + SETTLE); end
      end
    end
    cfg_mode = 0;
  endtask

  task automatic test_max_steps();
    bit to;
    clear_logs(); rd_value = DATA_W'($urandom());
    launch(1'b1, 16'hFFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    wait_done(70000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL max_timeout: done not seen within 70000 cycles"); end
    n_checks++; if (done_cyc - start_cyc != 7 + 65535 + SETTLE) begin n_fail++; $display("FAIL max_latency: got %0d required %0d", done_cyc - start_cyc, 7 + 65535 + SETTLE); end
    n_checks++; if (done_cyc - s3_cyc != 65535 + SETTLE + 3) begin n_fail++; $display("FAIL max_wait: got %0d required %0d", done_cyc - s3_cyc, 65535 + SETTLE + 3); end
    n_checks++; if (result !== rd_value) begin n_fail++; $display("FAIL max_result: got %h required %h", result, rd_value); end
  endtask

  initial begin
    test_reset();
    test_full_eval();
    test_skip_min();
    test_cfg_toggle();
    test_start_during_wait();
    test_reset_mid_cfg();
    test_random();
    test_max_steps();
    n_checks++;
    if (viol != 0) begin
      n_fail++; $display("FAIL bus_exclusivity: %0d violating cycles, required 0", viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ca_eval_sequencer.md
CA_EVAL_SEQUENCER -- requirements
Module: ca_eval_sequencer

Interface
REQ-001 Parameter CFG_WORDS, default 512, number of LUT configuration words written per evaluation.
REQ-002 Parameter ADDR_W, default 9, S2 address width; the block SHALL require 2**ADDR_W >= CFG_WORDS.
REQ-003 Parameter DATA_W, default 32, width of S1/S2 data and configuration words.
REQ-004 Parameter STEP_W, default 16, width of the step count driven on S3.
REQ-005 Parameter SETTLE, default 4, extra wait cycles after the step count elapses.
REQ-006 clk_in  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle evaluation request, honoured only in IDLE.
REQ-009 skip_cfg  in  1  sampled with start; 1 = reuse the configuration already loaded.
REQ-010 in_word, ctrl_word  in  DATA_W each  values written to S1 address 1 and address 0.
REQ-011 steps  in  STEP_W  CA step count, sampled with start.
REQ-012 cfg_valid / cfg_ready / cfg_data  in / out / in  1 / 1 / DATA_W  configuration stream, word transferred when both valid and ready are high.
REQ-013 busy / done / result  out / out / out  1 / 1 / DATA_W  busy high outside IDLE; done one-cycle pulse; result holds last readback.
REQ-014 s1_read, s1_write, s1_address, s1_writedata, s1_readdata  out, out, out, out, in  1, 1, 1, DATA_W, DATA_W  cell-array S1 master.
REQ-015 s2_write, s2_address, s2_writedata  out, out, out  1, ADDR_W, DATA_W  cell-array S2 master.
REQ-016 s3_write, s3_writedata  out, out  1, STEP_W  cell-array S3 master.

Function
REQ-017 States SHALL be IDLE, CFG, WR_IN, WR_CTRL, RUN, WAIT, READ, CAPTURE, DONE.
REQ-018 IDLE + start: latch steps, in_word, ctrl_word; go to CFG if skip_cfg=0, else WR_IN; start outside IDLE SHALL be ignored.
REQ-019 CFG: cfg_ready=1; each accepted word SHALL produce s2_write=1 the following cycle, with the address counting down from CFG_WORDS-1 to 0 and writedata equal to the accepted word.
REQ-020 CFG: cfg_valid low SHALL insert idle cycles with s2_write=0 and no address change; there is no timeout.
REQ-021 After the write to address 0, CFG SHALL go to WR_IN; cfg_ready SHALL be 0 outside CFG.
REQ-022 WR_IN: one cycle of s1_write=1, s1_address=1, s1_writedata=in_word; then WR_CTRL: one cycle of s1_write=1, s1_address=0, s1_writedata=ctrl_word.
REQ-023 RUN: one cycle of s3_write=1 with s3_writedata=latched steps; then WAIT.
REQ-024 WAIT SHALL last exactly steps+SETTLE cycles, with a counter of STEP_W+1 bits (no overflow at steps=2**STEP_W-1); steps=0 gives SETTLE cycles.
REQ-025 READ: one cycle of s1_read=1, s1_address=0; CAPTURE: result <= s1_readdata (one-cycle read latency).
REQ-026 DONE: done=1 for one cycle, then IDLE; busy SHALL fall in the same cycle done is asserted.
REQ-027 s1_read and s1_write SHALL never be high together; at most one of s1_write, s2_write, s3_write SHALL be high per cycle.
REQ-028 Write strobes SHALL be single-cycle pulses; address/data SHALL be stable while the associated strobe is high.
REQ-029 Minimum latency start->done with skip_cfg=1 SHALL be 7+steps+SETTLE cycles.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE regardless of state, including mid-CFG and mid-WAIT; the partial configuration is not restored.
REQ-031 Reset values: all strobes, busy, done, cfg_ready = 0; s1_address=0; s2_address=CFG_WORDS-1; s1/s2 writedata=0; s3_writedata=0; result=0.

Verification
REQ-032 Full eval: cfg stream 512 x 0x55555555 always valid, steps=100 -> 512 s2 writes at addresses 511..0, S1 writes 0xDEADBEEF@1 then 0xABCDEF12@0, one s3 pulse =100, done 104 cycles after s3 pulse +3, result = s1_readdata.
REQ-033 skip_cfg=1, steps=0, SETTLE=4 -> zero s2 writes, done exactly 11 cycles after start.
REQ-034 cfg_valid toggled every other cycle -> 512 writes, no address skipped or repeated, cfg_ready low after last word.
REQ-035 start pulsed during WAIT -> ignored; one done only; latched steps unchanged.
REQ-036 rst=0 after 200 CFG words -> next cycle all outputs at reset values; new start reloads from address 511.
REQ-037 steps=16'hFFFF -> WAIT lasts 65539 cycles, no wrap; assertion monitor confirms REQ-027 throughout all scenarios.
